div_issue_ctrl: RTL

Multi-cycle integer divide unit controller for the LoongArch execute stage. It accepts one divide micro-op at a time from the issue queue, latches the operands and destination, and sequences a radix-2 restoring iteration datapath. It handles sign pre- and post-processing and the divide-by-zero and small-dividend early-outs. The result is held on the writeback port until the writeback arbiter accepts it.

---
 rtl/div_issue_ctrl_pkg.sv | 29 ++
 rtl/div_radix2_step.sv | 28 ++
 rtl/div_issue_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared op codes, widths and FSM encoding for the integer divide issue controller.
package div_issue_ctrl_pkg;

    localparam int MIC_OP_W   = 8;
    localparam int ARCH_REG_W = 5;

    // Low bit clear selects a signed op; bit 1 selects the remainder result.
    localparam logic [MIC_OP_W-1:0] DIV_OP_DIVW  = 8'h40;
    localparam logic [MIC_OP_W-1:0] DIV_OP_DIVWU = 8'h41;
    localparam logic [MIC_OP_W-1:0] DIV_OP_MODW  = 8'h42;
    localparam logic [MIC_OP_W-1:0] DIV_OP_MODWU = 8'h43;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_ITER,
        DIV_FIX,
        DIV_DONE
    } div_state_e;

    function automatic logic op_is_signed(input logic [MIC_OP_W-1:0] op);
        return (op == DIV_OP_DIVW) || (op == DIV_OP_MODW);
    endfunction

    function automatic logic op_is_mod(input logic [MIC_OP_W-1:0] op);
        return (op == DIV_OP_MODW) || (op == DIV_OP_MODWU);
    endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_radix2_step #(
    parameter int WIDTH_DIV = 32
) (
    input  logic [WIDTH_DIV-1:0] rem_in,
    input  logic [WIDTH_DIV-1:0] quo_in,
    input  logic [WIDTH_DIV-1:0] divisor,
    output logic [WIDTH_DIV-1:0] rem_out,
    output logic [WIDTH_DIV-1:0] quo_out
);

    logic [WIDTH_DIV:0] shifted_rem;
    logic [WIDTH_DIV:0] diff;

    // rem_in < divisor always holds, so one extra bit is enough to see the borrow.
    always_comb begin
        shifted_rem = {rem_in, quo_in[WIDTH_DIV-1]};
        diff        = shifted_rem - {1'b0, divisor};
        if (!diff[WIDTH_DIV]) begin
            rem_out = diff[WIDTH_DIV-1:0];
            quo_out = {quo_in[WIDTH_DIV-2:0], 1'b1};
        end else begin
            rem_out = shifted_rem[WIDTH_DIV-1:0];
            quo_out = {quo_in[WIDTH_DIV-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Multi-cycle integer divide controller: operand latch, sign handling, early-outs,
// radix-2 iteration sequencing and a writeback hold until the arbiter grants.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int WIDTH_DIV  = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic                  Clk,
    input  logic                  Rest,
    input  logic [MIC_OP_W-1:0]   DivMicopcode,
    input  logic                  DivAbleValue,
    input  logic [WIDTH_DIV-1:0]  Dividend,
    input  logic [WIDTH_DIV-1:0]  Divisior,
    input  logic [ARCH_REG_W-1:0] DivWriteBack,
    input  logic                  FlushEn,
    input  logic                  WriteBackAck,
    output logic                  DivIqReq,
    output logic                  DivBusy,
    output logic                  WriteBackValid,
    output logic [WIDTH_DIV-1:0]  WriteBackData,
    output logic [ARCH_REG_W-1:0] WriteBackAddr
);

    div_state_e                   state;
    logic [ITER_CNT_W-1:0]        iter_cnt;
    logic [MIC_OP_W-1:0]          op_q;
    logic signed [WIDTH_DIV-1:0]  a_q;
    logic signed [WIDTH_DIV-1:0]  b_q;
    logic [ARCH_REG_W-1:0]        dst_q;
    logic [WIDTH_DIV-1:0]         div_b_q;
    logic [WIDTH_DIV-1:0]         rem_q;
    logic [WIDTH_DIV-1:0]         quo_q;
    logic                         qneg_q;
    logic                         rneg_q;
    logic                         op_signed;
    logic [WIDTH_DIV-1:0]         abs_a;
    logic [WIDTH_DIV-1:0]         abs_b;
    logic [WIDTH_DIV-1:0]         step_rem;
    logic [WIDTH_DIV-1:0]         step_quo;
    logic [WIDTH_DIV-1:0]         fix_q;
    logic [WIDTH_DIV-1:0]         fix_r;

    // INT_MIN negates to itself, which reads correctly as the unsigned magnitude 2^(W-1).
    function automatic logic [WIDTH_DIV-1:0] magnitude(input logic signed [WIDTH_DIV-1:0] v,
                                                       input logic is_signed);
        return (is_signed && v[WIDTH_DIV-1]) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH_DIV-1:0] apply_sign(input logic [WIDTH_DIV-1:0] v,
                                                        input logic neg);
        return neg ? (~v + WIDTH_DIV'(1)) : v;
    endfunction

    assign op_signed = op_is_signed(op_q);
    assign abs_a     = magnitude(a_q, op_signed);
    assign abs_b     = magnitude(b_q, op_signed);
    assign fix_q     = apply_sign(quo_q, qneg_q);
    assign fix_r     = apply_sign(rem_q, rneg_q);

    div_radix2_step #(
        .WIDTH_DIV (WIDTH_DIV)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (div_b_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Operand and iteration datapath; control below decides which state is live.
    always_ff @(posedge Clk) begin
        case (state)
            DIV_IDLE: begin
                if (DivAbleValue) begin
                    op_q  <= DivMicopcode;
                    a_q   <= Dividend;
                    b_q   <= Divisior;
                    dst_q <= DivWriteBack;
                end
            end
            DIV_PREP: begin
                div_b_q <= abs_b;
                qneg_q  <= op_signed & (a_q[WIDTH_DIV-1] ^ b_q[WIDTH_DIV-1]);
                rneg_q  <= op_signed & a_q[WIDTH_DIV-1];
                if (abs_b == '0) begin
                    quo_q  <= '1;
                    rem_q  <= a_q;
                    qneg_q <= 1'b0;
                    rneg_q <= 1'b0;
                end else if (abs_a < abs_b) begin
                    quo_q <= '0;
                    rem_q <= abs_a;
                end else begin
                    quo_q <= abs_a;
                    rem_q <= '0;
                end
            end
            DIV_ITER: begin
                rem_q <= step_rem;
                quo_q <= step_quo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state          <= DIV_IDLE;
            DivIqReq       <= 1'b1;
            DivBusy        <= 1'b0;
            WriteBackValid <= 1'b0;
            WriteBackData  <= '0;
            WriteBackAddr  <= '0;
            iter_cnt       <= '0;
        end else if (FlushEn) begin
            state          <= DIV_IDLE;
            DivIqReq       <= 1'b1;
            DivBusy        <= 1'b0;
            WriteBackValid <= 1'b0;
            iter_cnt       <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (DivAbleValue) begin
                        state    <= DIV_PREP;
                        DivIqReq <= 1'b0;
                        DivBusy  <= 1'b1;
                    end
                end
                DIV_PREP: begin
                    if ((abs_b == '0) || (abs_a < abs_b)) begin
                        state <= DIV_FIX;
                    end else begin
                        state    <= DIV_ITER;
                        iter_cnt <= ITER_CNT_W'(WIDTH_DIV);
                    end
                end
                DIV_ITER: begin
                    iter_cnt <= iter_cnt - ITER_CNT_W'(1);
                    if (iter_cnt == ITER_CNT_W'(1)) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    WriteBackValid <= 1'b1;
                    WriteBackData  <= op_is_mod(op_q) ? fix_r : fix_q;
                    WriteBackAddr  <= dst_q;
                    state          <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (WriteBackAck) begin
                        WriteBackValid <= 1'b0;
                        DivIqReq       <= 1'b1;
                        DivBusy        <= 1'b0;
                        state          <= DIV_IDLE;
                    end
                end
                default: begin
                    state    <= DIV_IDLE;
                    DivIqReq <= 1'b1;
                    DivBusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
